// File: rtl/store_lane_buffer.sv
// rtl/store_lane_buffer.sv - store lane narrowing and write FIFO between MEM stage and data memory
// Optional feature macro: STORE_MERGE_EN (merge same-word stores into the tail entry).
module store_lane_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_data,
    input  logic [1:0]       in_size,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic             misalign_err,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = CNT_W - 1;

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    logic        accept;
    logic        misaligned;
    logic        push;
    logic        pop;
    logic        merge;
    logic [31:0] lane_data;
    logic [3:0]  lane_be;

    assign in_ready     = (count_q != CNT_W'(DEPTH));
    assign mem_valid    = (count_q != '0);
    assign accept       = in_valid & in_ready;
    assign pop          = mem_valid & mem_ready;
    assign mem_addr     = {addr_q[rd_ptr_q], 2'b00};
    assign mem_wdata    = data_q[rd_ptr_q];
    assign mem_be       = be_q[rd_ptr_q];
    assign misalign_err = err_q;
    assign count        = count_q;

    // Replicate source bytes across all lanes so memory only needs byte enables.
    always_comb begin
        lane_data  = in_data;
        lane_be    = 4'b1111;
        misaligned = 1'b0;
        case (in_size)
            2'b00: begin
                lane_data = {4{in_data[7:0]}};
                lane_be   = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                lane_data  = {2{in_data[15:0]}};
                lane_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                misaligned = in_addr[0];
            end
            2'b10: begin
                lane_data  = in_data;
                lane_be    = 4'b1111;
                misaligned = |in_addr[1:0];
            end
            default: begin
                lane_data  = in_data;
                lane_be    = 4'b0000;
                misaligned = 1'b1;
            end
        endcase
    end

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0] tail_ptr;

    assign tail_ptr = wr_ptr_q - {{(PTR_W-1){1'b0}}, 1'b1};
    // A single-entry buffer being popped this cycle has no tail to merge into.
    assign merge = accept & ~misaligned & mem_valid
                 & (addr_q[tail_ptr] == in_addr[31:2])
                 & ~(pop & (count_q == CNT_W'(1)));
`else
    assign merge = 1'b0;
`endif

    assign push = accept & ~misaligned & ~merge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            err_q <= accept & misaligned;
            if (push) begin
                addr_q[wr_ptr_q] <= in_addr[31:2];
                data_q[wr_ptr_q] <= lane_data;
                be_q[wr_ptr_q]   <= lane_be;
                wr_ptr_q         <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
`ifdef STORE_MERGE_EN
            if (merge) begin
                be_q[tail_ptr] <= be_q[tail_ptr] | lane_be;
                for (int b = 0; b < 4; b++) begin
                    if (lane_be[b]) data_q[tail_ptr][b*8 +: 8] <= lane_data[b*8 +: 8];
                end
            end
`endif
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule
